// File: rtl/control_pipeline.sv
// control_pipeline: carries the decoded control bundle through EX/MEM/WB,
// stalls fetch/decode on a load-use hazard, flushes decode on a taken bne
// and keeps a saturating count of the bubbles it inserts into EX.
module control_pipeline #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [19:0]      ctrl_id,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic [1:0]       src_used_id,
  input  logic             src_vec_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             branch_taken_ex,
  input  logic             hold,
  output logic [19:0]      ctrl_ex,
  output logic [19:0]      ctrl_mem,
  output logic [19:0]      ctrl_wb,
  output logic [REG_W-1:0] rd_ex,
  output logic [REG_W-1:0] rd_mem,
  output logic [REG_W-1:0] rd_wb,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic [CNT_W-1:0] bubble_count
);

  logic [19:0]      ctrl_ex_r, ctrl_mem_r, ctrl_wb_r;
  logic [REG_W-1:0] rd_ex_r, rd_mem_r, rd_wb_r;
  logic [CNT_W-1:0] bubble_count_r;

  logic load_dst_s;   // EX holds a load writing the register file decode reads from
  logic src_hit_s;    // a source actually read in decode matches the EX destination
  logic lu_s;
  logic bubble_s;
  logic stall_s;
  logic flush_s;

  // Load-use hazard: a load in EX whose destination file and address match a used decode source.
  always_comb begin
    load_dst_s = ctrl_ex_r[18] &&
                 ((ctrl_ex_r[17] && !src_vec_id) || (ctrl_ex_r[16] && src_vec_id));
    src_hit_s  = (src_used_id[0] && (rs1_id == rd_ex_r)) ||
                 (src_used_id[1] && (rs2_id == rd_ex_r));
    lu_s       = load_dst_s && src_hit_s;
  end

  // Per-cycle action in priority order: hold, then branch flush, then load-use stall.
  always_comb begin
    stall_s  = 1'b0;
    flush_s  = 1'b0;
    bubble_s = 1'b0;
    if (hold) begin
      stall_s = 1'b1;
    end else if (branch_taken_ex) begin
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (lu_s) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
    end else begin
      stall_s  = 1'b0;
      flush_s  = 1'b0;
      bubble_s = 1'b0;
    end
  end

  // Pipeline registers: all stages advance together unless frozen; bit 19 is never propagated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_ex_r  <= 20'h00000;
      ctrl_mem_r <= 20'h00000;
      ctrl_wb_r  <= 20'h00000;
      rd_ex_r    <= {REG_W{1'b0}};
      rd_mem_r   <= {REG_W{1'b0}};
      rd_wb_r    <= {REG_W{1'b0}};
    end else if (!hold) begin
      if (bubble_s) begin
        ctrl_ex_r <= 20'h00000;
        rd_ex_r   <= {REG_W{1'b0}};
      end else begin
        ctrl_ex_r <= {1'b0, ctrl_id[18:0]};
        rd_ex_r   <= rd_id;
      end
      ctrl_mem_r <= ctrl_ex_r;
      rd_mem_r   <= rd_ex_r;
      ctrl_wb_r  <= ctrl_mem_r;
      rd_wb_r    <= rd_mem_r;
    end
  end

  // Bubble counter: one per inserted bubble, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_r <= {CNT_W{1'b0}};
    end else if (bubble_s && (bubble_count_r != {CNT_W{1'b1}})) begin
      bubble_count_r <= bubble_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ctrl_ex      = ctrl_ex_r;
  assign ctrl_mem     = ctrl_mem_r;
  assign ctrl_wb      = ctrl_wb_r;
  assign rd_ex        = rd_ex_r;
  assign rd_mem       = rd_mem_r;
  assign rd_wb        = rd_wb_r;
  assign stall_fd     = stall_s;
  assign flush_fd     = flush_s;
  assign bubble_count = bubble_count_r;

endmodule
